// File: rtl/pool_engine.sv
// Max-pooling sequencer: streams 2-pixel words from the pooled-feature buffer, reduces each
// window to its signed maximum and writes one value per window to the conv-input buffer.
module pool_engine #(
    parameter int unsigned DATSIZE = 22
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [3:0]             state_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   rd_en_o,
    output logic [5:0]             rd_y_o,
    output logic [5:0]             rd_x_o,
    output logic [5:0]             rd_c_o,
    output logic                   rd_updown_o,
    input  logic [2*DATSIZE-1:0]   rd_data_i,
    output logic                   wr_en_o,
    output logic [5:0]             wr_y_o,
    output logic [5:0]             wr_x_o,
    output logic [5:0]             wr_c_o,
    output logic [DATSIZE-1:0]     wr_data_o
);

    localparam logic [3:0] Pool1 = 4'b0011;
    localparam logic [3:0] Pool2 = 4'b0101;
    localparam logic [3:0] Pool3 = 4'b0111;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e st_q, st_d;
    logic [3:0] layer_q, layer_d;
    logic [5:0] c_q, c_d, oy_q, oy_d, ox_q, ox_d;
    logic [2:0] k_q, k_d;
    logic       busy_q, busy_d, done_q, done_d;
    logic       rd_en_q, rd_en_d, rd_updown_q, rd_updown_d;
    logic [5:0] rd_y_q, rd_y_d, rd_x_q, rd_x_d, rd_c_q, rd_c_d;
    // Pipeline stage describing the word arriving on rd_data_i this cycle.
    logic       vld_q, vld_d, plast_q, plast_d, pfirst_q, pfirst_d;
    logic [5:0] pc_q, pc_d, poy_q, poy_d, pox_q, pox_d;
    logic signed [DATSIZE-1:0] max_q, max_d;
    logic       wr_en_q, wr_en_d;
    logic [5:0] wr_y_q, wr_y_d, wr_x_q, wr_x_d, wr_c_q, wr_c_d;
    logic [DATSIZE-1:0] wr_data_q, wr_data_d;

    logic [5:0] last_c, last_o;
    logic [2:0] last_k;
    logic       last_read, abort, is8;
    logic signed [DATSIZE-1:0] lo_w, hi_w, wmax_w, fold_w;

    always_comb begin
        last_c = 6'd15;
        last_o = 6'd15;
        last_k = 3'd1;
        if (layer_q == Pool2) begin
            last_c = 6'd31;
            last_o = 6'd7;
        end else if (layer_q == Pool3) begin
            last_c = 6'd63;
            last_o = 6'd1;
            last_k = 3'd7;
        end
    end

    assign lo_w   = rd_data_i[DATSIZE-1:0];
    assign hi_w   = rd_data_i[2*DATSIZE-1:DATSIZE];
    assign wmax_w = (hi_w > lo_w) ? hi_w : lo_w;
    // First word of a window seeds the running max, so all-negative windows stay negative.
    assign fold_w = (pfirst_q || wmax_w > max_q) ? wmax_w : max_q;

    assign last_read = (k_q == last_k) && (ox_q == last_o) && (oy_q == last_o) && (c_q == last_c);
    assign abort     = (st_q != StIdle) && (state_i != layer_q);

    always_comb begin
        st_d      = st_q;
        layer_d   = layer_q;
        c_d       = c_q;
        oy_d      = oy_q;
        ox_d      = ox_q;
        k_d       = k_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        vld_d     = 1'b0;
        pfirst_d  = (k_q == 3'd0);
        plast_d   = (k_q == last_k);
        pc_d      = c_q;
        poy_d     = oy_q;
        pox_d     = ox_q;
        max_d     = max_q;
        wr_en_d   = 1'b0;
        wr_c_d    = 6'd0;
        wr_y_d    = 6'd0;
        wr_x_d    = 6'd0;
        wr_data_d = '0;

        unique case (st_q)
            StIdle: begin
                if (start_i && (state_i == Pool1 || state_i == Pool2 || state_i == Pool3)) begin
                    st_d    = StRun;
                    layer_d = state_i;
                    c_d     = 6'd0;
                    oy_d    = 6'd0;
                    ox_d    = 6'd0;
                    k_d     = 3'd0;
                    rd_en_d = 1'b1;
                end
            end
            StRun: begin
                vld_d = 1'b1;
                if (last_read) begin
                    st_d = StDrain;
                end else begin
                    rd_en_d = 1'b1;
                    k_d     = k_q + 3'd1;
                    if (k_q == last_k) begin
                        k_d  = 3'd0;
                        ox_d = ox_q + 6'd1;
                        if (ox_q == last_o) begin
                            ox_d = 6'd0;
                            oy_d = oy_q + 6'd1;
                            if (oy_q == last_o) begin
                                oy_d = 6'd0;
                                c_d  = c_q + 6'd1;
                            end
                        end
                    end
                end
            end
            StDrain: begin
                if (wr_en_q) begin
                    st_d   = StIdle;
                    done_d = 1'b1;
                end
            end
            default: st_d = StIdle;
        endcase

        if (vld_q) begin
            max_d = fold_w;
            if (plast_q) begin
                wr_en_d   = 1'b1;
                wr_c_d    = pc_q;
                wr_y_d    = poy_q;
                wr_x_d    = pox_q;
                wr_data_d = fold_w;
            end
        end

        if (abort) begin
            st_d    = StIdle;
            rd_en_d = 1'b0;
            vld_d   = 1'b0;
            wr_en_d = 1'b0;
            done_d  = 1'b0;
            c_d     = 6'd0;
            oy_d    = 6'd0;
            ox_d    = 6'd0;
            k_d     = 3'd0;
        end
    end

    assign is8    = (layer_d == Pool3);
    assign busy_d = (st_d != StIdle);

    always_comb begin
        rd_c_d      = 6'd0;
        rd_y_d      = 6'd0;
        rd_x_d      = 6'd0;
        rd_updown_d = 1'b0;
        if (rd_en_d) begin
            rd_c_d      = c_d;
            rd_y_d      = is8 ? {oy_d[4:0], k_d[2]} : oy_d;
            rd_x_d      = is8 ? {ox_d[4:0], k_d[0]} : ox_d;
            rd_updown_d = is8 ? k_d[1] : k_d[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q        <= StIdle;
            layer_q     <= 4'd0;
            c_q         <= 6'd0;
            oy_q        <= 6'd0;
            ox_q        <= 6'd0;
            k_q         <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_y_q      <= 6'd0;
            rd_x_q      <= 6'd0;
            rd_c_q      <= 6'd0;
            rd_updown_q <= 1'b0;
            vld_q       <= 1'b0;
            pfirst_q    <= 1'b0;
            plast_q     <= 1'b0;
            pc_q        <= 6'd0;
            poy_q       <= 6'd0;
            pox_q       <= 6'd0;
            max_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_y_q      <= 6'd0;
            wr_x_q      <= 6'd0;
            wr_c_q      <= 6'd0;
            wr_data_q   <= '0;
        end else begin
            st_q        <= st_d;
            layer_q     <= layer_d;
            c_q         <= c_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_y_q      <= rd_y_d;
            rd_x_q      <= rd_x_d;
            rd_c_q      <= rd_c_d;
            rd_updown_q <= rd_updown_d;
            vld_q       <= vld_d;
            pfirst_q    <= pfirst_d;
            plast_q     <= plast_d;
            pc_q        <= pc_d;
            poy_q       <= poy_d;
            pox_q       <= pox_d;
            max_q       <= max_d;
            wr_en_q     <= wr_en_d;
            wr_y_q      <= wr_y_d;
            wr_x_q      <= wr_x_d;
            wr_c_q      <= wr_c_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en_q;
    assign rd_y_o      = rd_y_q;
    assign rd_x_o      = rd_x_q;
    assign rd_c_o      = rd_c_q;
    assign rd_updown_o = rd_updown_q;
    assign wr_en_o     = wr_en_q;
    assign wr_y_o      = wr_y_q;
    assign wr_x_o      = wr_x_q;
    assign wr_c_o      = wr_c_q;
    assign wr_data_o   = wr_data_q;

endmodule
